// File: rtl/pc_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer: decodes the instruction class and drives
// PC/IR/regfile strobes, memory handshakes, the next-PC source select and a retire counter.
module pc_sequencer #(
  parameter int         CNT_W    = 32,
  parameter logic [5:0] JR_FUNCT = 6'b001000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             imemReady,
  input  logic             dmemReady,
  input  logic             stall,
  output logic             imemReq,
  output logic             dmemReq,
  output logic             dmemWrite,
  output logic             irWrite,
  output logic             pcWrite,
  output logic [1:0]       nPCFrom,
  output logic             regWrite,
  output logic             linkSel,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_ALU = 3'd0,
    C_LD  = 3'd1,
    C_ST  = 3'd2,
    C_JMP = 3'd3,
    C_JAL = 3'd4,
    C_BR  = 3'd5,
    C_JR  = 3'd6,
    C_ILL = 3'd7
  } cls_t;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_REG = 2'b11;

  state_t     st;
  cls_t       cls;
  cls_t       dec;
  logic [1:0] npc_q;
  logic [1:0] dec_npc;
  logic       act;
  logic       is_xfer;

  always_comb begin
    dec = C_ILL;
    case (opcode)
      6'b000000: dec = (funct == JR_FUNCT) ? C_JR : C_ALU;
      6'b000010: dec = C_JMP;
      6'b000011: dec = C_JAL;
      6'b000100,
      6'b000101: dec = C_BR;
      6'b100011: dec = C_LD;
      6'b101011: dec = C_ST;
      default:   dec = (opcode[5:3] == 3'b001) ? C_ALU : C_ILL;
    endcase
  end

  always_comb begin
    dec_npc = NPC_SEQ;
    case (dec)
      C_JMP, C_JAL: dec_npc = NPC_J;
      C_BR:         dec_npc = NPC_BR;
      C_JR:         dec_npc = NPC_REG;
      default:      dec_npc = NPC_SEQ;
    endcase
  end

  // Strobes are suppressed while held in reset as well as while stalled.
  assign act     = rst_n && !stall;
  assign is_xfer = (cls == C_JMP) || (cls == C_JAL) || (cls == C_BR) || (cls == C_JR);

  assign imemReq   = act && (st == S_IF);
  assign irWrite   = act && (st == S_IF) && imemReady;
  assign dmemReq   = act && (st == S_MEM);
  assign dmemWrite = act && (st == S_MEM) && (cls == C_ST);
  assign pcWrite   = act && (((st == S_EX) && is_xfer) ||
                             ((st == S_MEM) && (cls == C_ST) && dmemReady) ||
                             (st == S_WB));
  assign regWrite  = act && (((st == S_EX) && (cls == C_JAL)) ||
                             ((st == S_WB) && (cls != C_ILL)));
  assign linkSel   = act && (st == S_EX) && (cls == C_JAL);
  assign illegal   = act && (st == S_EX) && (cls == C_ILL);

  assign nPCFrom = npc_q;
  assign state   = st;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st      <= S_IF;
      cls     <= C_ALU;
      npc_q   <= NPC_SEQ;
      instret <= '0;
    end else if (!stall) begin
      if (pcWrite) begin
        instret <= instret + 1'b1;
        npc_q   <= NPC_SEQ;
      end
      case (st)
        S_IF: if (imemReady) st <= S_ID;
        S_ID: begin
          cls   <= dec;
          npc_q <= dec_npc;
          st    <= S_EX;
        end
        S_EX: begin
          case (cls)
            C_LD, C_ST:  st <= S_MEM;
            C_ALU, C_ILL: st <= S_WB;
            default:     st <= S_IF;
          endcase
        end
        S_MEM: if (dmemReady) st <= (cls == C_ST) ? S_IF : S_WB;
        S_WB:  st <= S_IF;
        default: st <= S_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench: walks hand-timed instructions through pc_sequencer and compares
// state, nPCFrom and every strobe each cycle; a narrow-counter copy checks wrap.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, funct;
  logic        imemReady, dmemReady, stall;
  logic        imemReq, dmemReq, dmemWrite, irWrite, pcWrite, regWrite, linkSel, illegal;
  logic [1:0]  nPCFrom;
  logic [2:0]  state;
  logic [31:0] instret;

  logic        w_imemReq, w_dmemReq, w_dmemWrite, w_irWrite, w_pcWrite, w_regWrite;
  logic        w_linkSel, w_illegal;
  logic [1:0]  w_nPCFrom;
  logic [2:0]  w_state;
  logic [1:0]  w_instret;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.CNT_W(32), .JR_FUNCT(6'b001000)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .imemReady(imemReady), .dmemReady(dmemReady), .stall(stall),
    .imemReq(imemReq), .dmemReq(dmemReq), .dmemWrite(dmemWrite), .irWrite(irWrite),
    .pcWrite(pcWrite), .nPCFrom(nPCFrom), .regWrite(regWrite), .linkSel(linkSel),
    .illegal(illegal), .state(state), .instret(instret)
  );

  pc_sequencer #(.CNT_W(2), .JR_FUNCT(6'b001000)) dut_w (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .imemReady(imemReady), .dmemReady(dmemReady), .stall(stall),
    .imemReq(w_imemReq), .dmemReq(w_dmemReq), .dmemWrite(w_dmemWrite), .irWrite(w_irWrite),
    .pcWrite(w_pcWrite), .nPCFrom(w_nPCFrom), .regWrite(w_regWrite), .linkSel(w_linkSel),
    .illegal(w_illegal), .state(w_state), .instret(w_instret)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else
      passed++;
  endtask

  // Strobe order: imemReq irWrite pcWrite regWrite linkSel dmemReq dmemWrite illegal
  task automatic ex(input string tag, input logic [2:0] st, input logic [1:0] np,
                    input logic [7:0] sb);
    #1;
    chk(tag, {19'd0, state, nPCFrom, imemReq, irWrite, pcWrite, regWrite, linkSel,
              dmemReq, dmemWrite, illegal}, {19'd0, st, np, sb});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = 6'd0; funct = 6'b100001;
    imemReady = 1'b1; dmemReady = 1'b1; stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ex("reset_hold", 3'd0, 2'b00, 8'b00000000);
    chk("reset_instret", instret, 32'd0);
    rst_n = 1'b1;

    // ADDU
    ex("addu_if",  3'd0, 2'b00, 8'b11000000);
    ex("addu_id",  3'd1, 2'b00, 8'b00000000);
    ex("addu_ex",  3'd2, 2'b00, 8'b00000000);
    chk("addu_pre_instret", instret, 32'd0);
    ex("addu_wb",  3'd4, 2'b00, 8'b00110000);
    chk("addu_instret", instret, 32'd1);

    // LW with three dmem wait cycles
    opcode = 6'b100011; dmemReady = 1'b0;
    ex("lw_if",    3'd0, 2'b00, 8'b11000000);
    ex("lw_id",    3'd1, 2'b00, 8'b00000000);
    ex("lw_ex",    3'd2, 2'b00, 8'b00000000);
    for (int i = 0; i < 3; i++) ex("lw_mem_wait", 3'd3, 2'b00, 8'b00000100);
    dmemReady = 1'b1;
    ex("lw_mem_rdy", 3'd3, 2'b00, 8'b00000100);
    ex("lw_wb",    3'd4, 2'b00, 8'b00110000);
    chk("lw_instret", instret, 32'd2);

    // JR
    opcode = 6'd0; funct = 6'b001000;
    ex("jr_if",    3'd0, 2'b00, 8'b11000000);
    ex("jr_id",    3'd1, 2'b00, 8'b00000000);
    ex("jr_ex",    3'd2, 2'b11, 8'b00100000);
    // JAL then BEQ back-to-back
    opcode = 6'b000011;
    ex("jal_if",   3'd0, 2'b00, 8'b11000000);
    ex("jal_id",   3'd1, 2'b00, 8'b00000000);
    ex("jal_ex",   3'd2, 2'b10, 8'b00111000);
    chk("wrap_instret", {30'd0, w_instret}, 32'd0);
    opcode = 6'b000100;
    ex("beq_if",   3'd0, 2'b00, 8'b11000000);
    ex("beq_id",   3'd1, 2'b00, 8'b00000000);
    ex("beq_ex",   3'd2, 2'b01, 8'b00100000);
    chk("branch_instret", instret, 32'd5);

    // SW stalled three cycles in MEM with dmemReady high
    opcode = 6'b101011;
    ex("sw_if",    3'd0, 2'b00, 8'b11000000);
    ex("sw_id",    3'd1, 2'b00, 8'b00000000);
    stall = 1'b1;
    ex("sw_ex_stall", 3'd2, 2'b00, 8'b00000000);
    stall = 1'b0;
    ex("sw_ex",    3'd2, 2'b00, 8'b00000000);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) ex("sw_mem_stall", 3'd3, 2'b00, 8'b00000000);
    chk("stall_instret", instret, 32'd5);
    stall = 1'b0;
    ex("sw_mem",   3'd3, 2'b00, 8'b00100110);
    chk("sw_instret", instret, 32'd6);

    // Illegal opcode, with one fetch wait
    opcode = 6'b111111; imemReady = 1'b0;
    ex("ill_if_wait", 3'd0, 2'b00, 8'b10000000);
    imemReady = 1'b1;
    ex("ill_if",   3'd0, 2'b00, 8'b11000000);
    ex("ill_id",   3'd1, 2'b00, 8'b00000000);
    ex("ill_ex",   3'd2, 2'b00, 8'b00000001);
    ex("ill_wb",   3'd4, 2'b00, 8'b00100000);
    chk("ill_instret", instret, 32'd7);
    chk("wrap_instret2", {30'd0, w_instret}, 32'd3);

    // Reset mid-instruction abandons the BEQ before its commit
    opcode = 6'b000100;
    ex("mid_if",   3'd0, 2'b00, 8'b11000000);
    ex("mid_id",   3'd1, 2'b00, 8'b00000000);
    rst_n = 1'b0;
    ex("mid_rst",  3'd2, 2'b01, 8'b00000000);
    chk("mid_rst_instret", instret, 32'd0);
    rst_n = 1'b1;
    ex("post_rst_if", 3'd0, 2'b00, 8'b11000000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
